// File: rtl/signal_trace_buffer.sv
// ECG/EMG capture store with per-frame frozen, oldest-first read windows.
// Optional trigger/hold capture enabled by defining TRACE_TRIGGER_EN.
module signal_trace_buffer #(
    parameter int          DEPTH      = 320,
    parameter logic [11:0] ECG_BASE   = 12'h559,
    parameter logic [11:0] EMG_BASE   = 12'h6AD,
    parameter int          DECIM      = 1,
    parameter logic [11:0] TRIG_LEVEL = 12'h800
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_chan,
    input  logic [11:0] s_data,
    input  logic        frame_start,
    input  logic [11:0] sig_addr,
    output logic [31:0] sig_data,
    output logic [1:0]  filled,
    input  logic        trig_rearm
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [9:0]  DEPTH10 = 10'(DEPTH);
    localparam logic [11:0] ECG_END = ECG_BASE + 12'(DEPTH);
    localparam logic [11:0] EMG_END = EMG_BASE + 12'(DEPTH);

    typedef enum logic [1:0] {CLEAR, RUN, HOLD} state_t;
    state_t state, state_nxt;

    logic [11:0] mem_ecg [DEPTH];
    logic [11:0] mem_emg [DEPTH];
    logic [9:0]  clr_idx;
    logic [9:0]  wr_ptr  [2];
    logic [9:0]  cnt     [2];
    logic [9:0]  rd_base [2];
    logic [3:0]  dec_cnt [2];
    logic [1:0]  st, adv;
    logic        acc, post_done, rearm;

    assign s_ready = (state == RUN) || (state == HOLD);
    assign acc     = s_valid && s_ready;

    always_comb begin
        st  = 2'b00;
        adv = 2'b00;
        for (int c = 0; c < 2; c++) begin
            adv[c] = acc && (state == RUN) && (s_chan == 1'(c));
            st[c]  = adv[c] && (dec_cnt[c] == 4'd0);
        end
    end

`ifdef TRACE_TRIGGER_EN
    logic [11:0] prev_ecg;
    logic        armed;
    logic [9:0]  post_cnt;
    logic        trig_hit;

    assign trig_hit  = st[0] && filled[0] && !armed &&
                       (prev_ecg < TRIG_LEVEL) && (s_data >= TRIG_LEVEL);
    assign post_done = st[0] && armed && (post_cnt == 10'(DEPTH / 2 - 1));
    assign rearm     = trig_rearm;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_ecg <= 12'd0;
            armed    <= 1'b0;
            post_cnt <= 10'd0;
        end else begin
            if (st[0]) prev_ecg <= s_data;
            if (trig_hit) begin
                armed    <= 1'b1;
                post_cnt <= 10'd0;
            end else if (post_done) begin
                armed    <= 1'b0;
            end else if (st[0] && armed) begin
                post_cnt <= post_cnt + 10'd1;
            end
        end
    end
`else
    logic unused_rearm;
    assign unused_rearm = trig_rearm;
    assign post_done    = 1'b0;
    assign rearm        = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= CLEAR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR:   if (clr_idx == DEPTH10 - 10'd1) state_nxt = RUN;
            RUN:     if (post_done) state_nxt = HOLD;
            HOLD:    if (rearm) state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    // Buffer storage carries no reset; CLEAR zeroes it one index per cycle.
    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            mem_ecg[clr_idx[AW-1:0]] <= 12'd0;
            mem_emg[clr_idx[AW-1:0]] <= 12'd0;
        end else begin
            if (st[0]) mem_ecg[wr_ptr[0][AW-1:0]] <= s_data;
            if (st[1]) mem_emg[wr_ptr[1][AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clr_idx <= 10'd0;
            filled  <= 2'b00;
            for (int c = 0; c < 2; c++) begin
                wr_ptr[c]  <= 10'd0;
                cnt[c]     <= 10'd0;
                rd_base[c] <= 10'd0;
                dec_cnt[c] <= 4'd0;
            end
        end else begin
            if (state == CLEAR) clr_idx <= clr_idx + 10'd1;
            for (int c = 0; c < 2; c++) begin
                if (frame_start)
                    rd_base[c] <= filled[c] ? wr_ptr[c] : 10'd0;
                if (adv[c])
                    dec_cnt[c] <= (dec_cnt[c] == 4'(DECIM - 1)) ? 4'd0 : dec_cnt[c] + 4'd1;
                if (st[c]) begin
                    wr_ptr[c] <= (wr_ptr[c] == DEPTH10 - 10'd1) ? 10'd0 : wr_ptr[c] + 10'd1;
                    if (cnt[c] != DEPTH10) cnt[c] <= cnt[c] + 10'd1;
                    if (cnt[c] >= DEPTH10 - 10'd1) filled[c] <= 1'b1;
                end
            end
        end
    end

    logic [9:0] off_ecg, off_emg, sum_ecg, sum_emg, idx_ecg, idx_emg;
    logic       hit_ecg, hit_emg;

    assign hit_ecg = (sig_addr >= ECG_BASE) && (sig_addr < ECG_END);
    assign hit_emg = (sig_addr >= EMG_BASE) && (sig_addr < EMG_END);
    assign off_ecg = 10'(sig_addr - ECG_BASE);
    assign off_emg = 10'(sig_addr - EMG_BASE);
    assign sum_ecg = rd_base[0] + off_ecg;
    assign sum_emg = rd_base[1] + off_emg;
    assign idx_ecg = (sum_ecg >= DEPTH10) ? sum_ecg - DEPTH10 : sum_ecg;
    assign idx_emg = (sum_emg >= DEPTH10) ? sum_emg - DEPTH10 : sum_emg;

    always_ff @(posedge clock) begin
        if (reset || state == CLEAR) begin
            sig_data <= 32'd0;
        end else begin
            unique case (1'b1)
                hit_ecg: sig_data <= {20'd0, mem_ecg[idx_ecg[AW-1:0]]};
                hit_emg: sig_data <= {20'd0, mem_emg[idx_emg[AW-1:0]]};
                default: sig_data <= 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_signal_trace_buffer.sv
// Scoreboard bench for signal_trace_buffer: DECIM=1 and DECIM=4 instances
// share stimulus; reads are queued with expected data and checked on return.
module tb_signal_trace_buffer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_chan = 1'b0;
    logic [11:0] s_data = 12'd0;
    logic        frame_start = 1'b0;
    logic [11:0] sig_addr = 12'd0;
    logic        trig_rearm = 1'b0;
    logic        s_ready, s_ready4;
    logic [31:0] sig_data, sig_data4;
    logic [1:0]  filled, filled4;

    int checks = 0;
    int errors = 0;

    logic        rd_issue = 1'b0;
    logic        rd_v = 1'b0;
    logic [32:0] sb[$];

    always #5 clock = ~clock;

    signal_trace_buffer #(.DECIM(1)) dut (
        .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_chan(s_chan), .s_data(s_data), .frame_start(frame_start),
        .sig_addr(sig_addr), .sig_data(sig_data), .filled(filled),
        .trig_rearm(trig_rearm)
    );

    signal_trace_buffer #(.DECIM(4)) dut4 (
        .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready4),
        .s_chan(s_chan), .s_data(s_data), .frame_start(frame_start),
        .sig_addr(sig_addr), .sig_data(sig_data4), .filled(filled4),
        .trig_rearm(trig_rearm)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clock) rd_v <= rd_issue;

    always @(negedge clock) begin
        if (rd_v) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check(e[32] ? "read_d4" : "read_d1",
                      e[32] ? sig_data4 : sig_data, e[31:0]);
            end
        end
    end

    task automatic rd(input logic sel, input logic [11:0] a,
                      input logic [31:0] exp);
        sig_addr = a;
        rd_issue = 1'b1;
        sb.push_back({sel, exp});
        @(negedge clock);
        rd_issue = 1'b0;
    endtask

    task automatic send(input logic ch, input logic [11:0] d,
                        input logic fs);
        s_valid     = 1'b1;
        s_chan      = ch;
        s_data      = d;
        frame_start = fs;
        @(negedge clock);
        s_valid     = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
    endtask

    task automatic wait_clear(input int start, output int n);
        n = start;
        while (!s_ready && n < 400) begin
            @(negedge clock);
            n++;
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        check("reset_s_ready", 32'(s_ready), 32'd0);
        check("reset_sig_data", sig_data, 32'd0);
        check("reset_filled", 32'(filled), 32'd0);

        reset = 1'b0;
        rd(1'b0, 12'h559, 32'd0);
        wait_clear(1, n);
        check("clear_cycles", n, 32'd320);
        check("clear_ready_d4", 32'(s_ready4), 32'd1);

        for (int i = 1; i <= 10; i++) send(1'b0, 12'(i), 1'b0);
        frame();
        rd(1'b0, 12'h559, 32'd1);
        rd(1'b0, 12'h562, 32'd10);
        rd(1'b0, 12'h563, 32'd0);
        check("filled_partial", 32'(filled), 32'd0);

        for (int i = 0; i < 330; i++) send(1'b0, 12'(i), 1'b0);
        frame();
        rd(1'b0, 12'h559, 32'd10);
        rd(1'b0, 12'h698, 32'd329);
        rd(1'b0, 12'h558, 32'd0);
        rd(1'b0, 12'h699, 32'd0);
        check("filled_ecg", 32'(filled), 32'd1);

        send(1'b0, 12'd999, 1'b1);
        rd(1'b0, 12'h698, 32'd329);
        rd(1'b0, 12'h559, 32'd999);
        frame();
        rd(1'b0, 12'h559, 32'd11);
        rd(1'b0, 12'h698, 32'd999);

        for (int i = 0; i < 16; i++) send(1'b1, 12'(i), 1'b0);
        frame();
        rd(1'b1, 12'h6AD, 32'd0);
        rd(1'b1, 12'h6AE, 32'd4);
        rd(1'b1, 12'h6AF, 32'd8);
        rd(1'b1, 12'h6B0, 32'd12);
        rd(1'b1, 12'h6B1, 32'd0);
        rd(1'b0, 12'h6BC, 32'd15);

        for (int i = 0; i < 100; i++) send(1'b1, 12'(i + 100), 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_s_ready", 32'(s_ready), 32'd0);
        check("midreset_s_ready_d4", 32'(s_ready4), 32'd0);
        check("midreset_filled", 32'(filled), 32'd0);
        reset = 1'b0;
        wait_clear(0, n);
        check("reclear_cycles", n, 32'd320);
        frame();
        rd(1'b0, 12'h559, 32'd0);
        rd(1'b0, 12'h698, 32'd0);
        rd(1'b0, 12'h6AD, 32'd0);
        rd(1'b1, 12'h6AD, 32'd0);

        repeat (3) @(negedge clock);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/signal_trace_buffer.md
Name: signal_trace_buffer

Overview:
Capture store for the two biosignal traces, ECG on channel 0 and EMG on channel 1, drawn by the VGA display stage. It accepts 12-bit samples from the acquisition path through a valid/ready handshake and keeps the last DEPTH samples per channel in circular buffers. It serves the display's sig_addr/sig_data read port, presenting each window oldest-first. The read view is frozen once per video frame so traces do not tear.

Parameters:
DEPTH, 320, samples stored per channel (display points per trace)
ECG_BASE, 12'h559, first read address of the channel-0 window
EMG_BASE, 12'h6AD, first read address of the channel-1 window
DECIM, 1, keep every DECIM-th accepted sample per channel (1..16)
TRIG_LEVEL, 12'h800, trigger threshold (optional feature only)

Ports:
clock  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
s_valid  in  1  sample valid
s_ready  out  1  buffer can accept a sample
s_chan  in  1  0 = ECG, 1 = EMG
s_data  in  12  sample value
frame_start  in  1  one-cycle pulse at start of each video frame
sig_addr  in  12  display read address
sig_data  out  32  read data, {20'b0, sample}
filled  out  2  per-channel flag: DEPTH samples stored
trig_rearm  in  1  re-arm pulse (used only with optional feature)

Behaviour:
- Reset values: s_ready=0, sig_data=0, filled=0. Write pointers, counts, snapshot bases and decimation counters are all 0. State goes to CLEAR.
- CLEAR state:
  - An index counter runs 0..DEPTH-1 and writes 0 to both channel buffers, one index per cycle.
  - Exactly DEPTH cycles later the state moves to RUN and s_ready goes 1.
  - sig_data reads 0 throughout CLEAR.
- RUN state:
  - s_ready=1. A sample is accepted when s_valid && s_ready.
  - Each channel has a decimation counter, 0..DECIM-1, that advances on every accepted sample for that channel and wraps.
  - The sample is stored only when the counter is 0 before the increment.
  - A store writes mem[ch][wr_ptr[ch]] and advances wr_ptr with wrap (DEPTH-1 goes to 0).
  - count[ch] saturates at DEPTH; filled[ch] = (count[ch]==DEPTH), registered.
- Frame snapshot:
  - On frame_start, rd_base[ch] <= filled[ch] ? wr_ptr[ch] : 0.
  - If frame_start coincides with a store, the snapshot uses the pre-store pointer.
- Read path (1-cycle latency):
  - If sig_addr is in [BASE, BASE+DEPTH) for a channel: off = sig_addr-BASE, idx = rd_base+off, minus DEPTH if idx >= DEPTH.
  - sig_data <= {20'b0, mem[ch][idx]} on the next clock edge.
  - Any other address returns sig_data <= 0.
  - Entries not yet written read 0 because CLEAR zeroed them.
- Read and write of the same index in the same cycle returns the old value (read-first).
- Reset asserted mid-operation aborts any state; the block restarts CLEAR from index 0.
- Index arithmetic is 10 bits wide; address compare is 12 bits unsigned.

Optional Feature:
Macro TRACE_TRIGGER_EN.
- Defined: adds a HOLD state.
  - In RUN, once filled[0]=1, an ECG store with prev_ecg < TRIG_LEVEL <= s_data arms a post-trigger counter.
  - After DEPTH/2 further ECG stores, the block enters HOLD.
  - In HOLD, s_ready stays 1 but all samples are discarded; pointers, counts and decimation counters are frozen.
  - trig_rearm returns the block to RUN; the next trigger requires a new crossing.
  - frame_start still snapshots in HOLD.
- Not defined: no HOLD state; trig_rearm is ignored; behaviour is the RUN free-roll only.

Test Plan:
- Reset released at cycle 0 -> s_ready=0 for cycles 1..320 and =1 on cycle 321; read of 12'h559 during CLEAR -> 0.
- DECIM=1: write ECG 1..10, pulse frame_start -> addr 12'h559 gives 32'd1 one cycle later, 12'h562 gives 10, 12'h563 gives 0; filled=2'b00.
- Write 330 ECG samples valued 0..329, frame_start -> filled[0]=1; 12'h559 gives 10, 12'h698 gives 329; 12'h558 and 12'h699 give 0.
- DECIM=4: EMG samples 0..15 then frame_start -> 12'h6AD..12'h6B0 give 0,4,8,12 and 12'h6B1 gives 0. Also pulse frame_start on the same cycle as a store and check the snapshot excludes that store.
- Reset asserted mid-RUN after 100 stores -> s_ready drops next cycle, CLEAR repeats for 320 cycles, and all reads give 0 afterwards.
- TRACE_TRIGGER_EN, buffer filled with 12'h100: ECG sample 12'h900 crosses -> HOLD after 160 more ECG stores, further samples are ignored and reads are stable; trig_rearm resumes storing.
